mem_copy_engine: RTL
====================

Name: mem_copy_engine

Overview:
- Initiator (master) for the single-port 32-bit data memory port (wrt, read, address, data_in, data_out).
- Performs block copy (memory-to-memory) or block fill (constant pattern) of N words on a start pulse.
- Sits beside the register file/datapath so the lab CPU and testbenches can move or initialise data-memory regions without per-word instructions.

Parameters:
- IDX_W, 16, memory word-index width; only address[IDX_W-1:0] is significant to the memory.
- LEN_W, 17, width of the length and count fields; 65536 words must be expressible.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- mode  input  1  0 = copy, 1 = fill; captured at start.
- src_addr  input  32  copy source base word address; captured at start.
- dst_addr  input  32  destination base word address; captured at start.
- length  input  LEN_W  number of words; captured at start.
- pattern  input  32  fill value; captured at start.
- abort  input  1  stop the transfer at the next edge.
- busy  output  1  high from the cycle after start until the cycle done pulses.
- done  output  1  one-cycle completion pulse.
- aborted  output  1  high together with done when the transfer was aborted; holds until the next start.
- count  output  LEN_W  words written so far.
- mem_wrt  output  1  memory write strobe.
- mem_read  output  1  memory read strobe.
- mem_address  output  32  word address to memory.
- mem_data_in  output  32  write data to memory.
- mem_data_out  input  32  registered read data from memory; valid the cycle after mem_read.

Behaviour:
- Memory contract:
  - The memory acts on the posedge where read or wrt is high; read has priority.
  - The engine never asserts mem_read and mem_wrt in the same cycle.
- Reset (async, rst_n=0):
  - State = IDLE.
  - busy=0, done=0, aborted=0, count=0, mem_wrt=0, mem_read=0, mem_address=0, mem_data_in=0.
  - Captured registers are cleared.
  - Reset mid-transfer abandons the transfer immediately; no further strobes.
- States: IDLE, RD, WR, FILL, FIN.
- IDLE:
  - When start=1: capture inputs, set count=0, clear aborted.
  - length=0 -> FIN.
  - Else mode=0 -> RD, mode=1 -> FILL.
  - start while busy is ignored.
- RD:
  - mem_read=1.
  - mem_address = {zeros, (src[IDX_W-1:0] + count) mod 2^IDX_W}.
  - Next state is WR.
- WR:
  - mem_wrt=1.
  - mem_address = {zeros, (dst[IDX_W-1:0] + count) mod 2^IDX_W}.
  - mem_data_in = mem_data_out (combinational pass-through; stable because read=0).
  - At the edge, count increments.
  - If count+1 == length -> FIN, else -> RD.
- FILL:
  - mem_wrt=1, address = dst+count, mem_data_in = pattern.
  - count increments each edge.
  - Exit to FIN when count+1 == length.
- Throughput: copy takes 2 cycles/word; fill takes 1 cycle/word.
- FIN: done=1 for one cycle, busy drops in the same cycle, return to IDLE.
- Latency: start edge -> first strobe is the next cycle.
  - Copy of N words: done is asserted 2N+1 cycles after start.
  - Fill of N words: done is asserted N+1 cycles after start.
  - length=0: done is asserted 1 cycle after start.
- Address wrap: index arithmetic wraps modulo 2^IDX_W (0xFFFF+1 -> 0x0000). Upper 16 address bits are always driven 0.
- Overlap: strictly forward word-by-word semantics. If dst is in (src, src+len), the copy propagates already-written words; this is defined behaviour, not an error.
- abort in RD/WR/FILL:
  - The strobe asserted in that cycle still completes at the edge, and count reflects it.
  - Next state is FIN with aborted=1.
  - abort in IDLE/FIN has no effect.
  - abort together with start in IDLE: start wins; abort is ignored that cycle.
- Outputs in IDLE/FIN: mem_read=0, mem_wrt=0, mem_address and mem_data_in hold 0.

Test Plan:
- Reset: rst_n low mid-copy at cycle 3 -> all outputs 0 asynchronously; memory untouched afterwards; busy=0.
- Copy: preload mem[0x10..0x13] = 0xA0..0xA3, start copy src=0x10, dst=0x40, len=4 -> mem[0x40..0x43] = 0xA0..0xA3; done exactly 9 cycles after start; count=4; source unchanged.
- Fill with wrap: fill dst=0xFFFE, len=3, pattern=0xDEADBEEF -> mem[0xFFFE], mem[0xFFFF] and mem[0x0000] = 0xDEADBEEF; done 4 cycles after start; mem_address[31:16] always 0.
- Zero length / busy start: len=0 -> done 1 cycle later, no strobes. A second start during a 4-word copy is ignored, with no parameter change.
- Abort: copy len=8 src=0x100 dst=0x200, assert abort in the 3rd WR cycle -> exactly 3 words written; done and aborted both =1; count=3; mem[0x203] untouched.
- Overlap: mem[0..3] = 1,2,3,4, copy src=0 dst=1 len=3 -> mem[0..3] = 1,1,1,1 (forward semantics).

Source files
------------

// File: rtl/mem_copy_engine.sv
// Block copy / block fill master for the single-port 32-bit data memory.
// Copy alternates RD/WR (2 cycles/word); fill writes one word per cycle.
module mem_copy_engine #(
  parameter int IDX_W = 16,
  parameter int LEN_W = 17
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] length,
  input  logic [31:0]      pattern,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [LEN_W-1:0] count,
  output logic             mem_wrt,
  output logic             mem_read,
  output logic [31:0]      mem_address,
  output logic [31:0]      mem_data_in,
  input  logic [31:0]      mem_data_out
);

  typedef enum logic [2:0] {IDLE, RD, WR, FILL, FIN} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] src_idx;
  logic [IDX_W-1:0] dst_idx;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] count_q;
  logic [31:0]      pattern_q;
  logic             aborted_q;

  logic [LEN_W-1:0] count_inc;
  logic             last_word;
  logic [IDX_W-1:0] src_ofs;
  logic [IDX_W-1:0] dst_ofs;
  logic             unused_hi;

  assign count_inc = count_q + 1'b1;
  assign last_word = (count_inc == len_q);
  // Index arithmetic deliberately truncates to IDX_W so addresses wrap.
  assign src_ofs   = src_idx + count_q[IDX_W-1:0];
  assign dst_ofs   = dst_idx + count_q[IDX_W-1:0];
  assign unused_hi = ^{src_addr[31:IDX_W], dst_addr[31:IDX_W]};

  assign busy    = (state == RD) || (state == WR) || (state == FILL);
  assign done    = (state == FIN);
  assign aborted = aborted_q;
  assign count   = count_q;

  always_comb begin
    state_nxt   = state;
    mem_read    = 1'b0;
    mem_wrt     = 1'b0;
    mem_address = '0;
    mem_data_in = '0;
    case (state)
      IDLE: begin
        if (start) begin
          if (length == '0) state_nxt = FIN;
          else if (mode)    state_nxt = FILL;
          else              state_nxt = RD;
        end
      end
      RD: begin
        mem_read    = 1'b1;
        mem_address = 32'(src_ofs);
        state_nxt   = abort ? FIN : WR;
      end
      WR: begin
        // Read data is registered in the memory and stays stable while read=0.
        mem_wrt     = 1'b1;
        mem_address = 32'(dst_ofs);
        mem_data_in = mem_data_out;
        state_nxt   = (abort || last_word) ? FIN : RD;
      end
      FILL: begin
        mem_wrt     = 1'b1;
        mem_address = 32'(dst_ofs);
        mem_data_in = pattern_q;
        state_nxt   = (abort || last_word) ? FIN : FILL;
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      src_idx   <= '0;
      dst_idx   <= '0;
      len_q     <= '0;
      count_q   <= '0;
      pattern_q <= '0;
      aborted_q <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            src_idx   <= src_addr[IDX_W-1:0];
            dst_idx   <= dst_addr[IDX_W-1:0];
            len_q     <= length;
            pattern_q <= pattern;
            count_q   <= '0;
            aborted_q <= 1'b0;
          end
        end
        RD: begin
          if (abort) aborted_q <= 1'b1;
        end
        WR, FILL: begin
          // The write in flight this cycle completes, so it is counted even on abort.
          count_q <= count_inc;
          if (abort) aborted_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
